// File: rtl/coh_noc_pkg.sv
// rtl/coh_noc_pkg.sv - shared coh_noc link constants
// Credit width is shared with the sender's credit counter so both ends agree on range.
package coh_noc_pkg;
  localparam int VC_ID_WIDTH        = 2;
  localparam int FLIT_WIDTH_DEFAULT = 128;
  localparam int MAX_CREDITS        = 16;
  localparam int CREDIT_COUNT_WIDTH = $clog2(MAX_CREDITS + 1);
endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single-VC circular flit FIFO
// Pushes when full and pops when empty are ignored; the caller flags overflow.
module vc_fifo #(
  parameter int DEPTH       = 16,
  parameter int FLIT_WIDTH  = 128,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [FLIT_WIDTH-1:0]  data_i,
  output logic [FLIT_WIDTH-1:0]  head_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [FLIT_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   do_push, do_pop;

  assign full_o  = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - per-VC input buffer with round-robin output and credit return
// Output side is driven purely from registered state; the grant freezes while stalled.
module vc_input_buffer
  import coh_noc_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int NUM_VCS    = 4,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [VC_ID_WIDTH-1:0]        in_vc_id,
  input  logic [FLIT_WIDTH-1:0]         in_flit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VC_ID_WIDTH-1:0]        out_vc_id,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic                          return_credit,
  output logic [VC_ID_WIDTH-1:0]        return_vc_id,
  output logic [CREDIT_COUNT_WIDTH-1:0] occupancy [NUM_VCS],
  output logic                          overflow_err
);
  logic [NUM_VCS-1:0]     empty, full, push_vec, pop_vec;
  logic [FLIT_WIDTH-1:0]  head [NUM_VCS];
  logic [VC_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                   lock_q, lock_d;
  logic [VC_ID_WIDTH-1:0] lock_vc_q, lock_vc_d;
  logic                   ret_q, ret_d;
  logic [VC_ID_WIDTH-1:0] ret_vc_q, ret_vc_d;
  logic                   ovf_q, ovf_d;
  logic [VC_ID_WIDTH-1:0] grant_rr, grant;
  logic                   found;
  logic                   pop;
  int                     idx;

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    assign push_vec[g] = in_valid && (in_vc_id == VC_ID_WIDTH'(g));
    assign pop_vec[g]  = pop && (grant == VC_ID_WIDTH'(g));

    vc_fifo #(
      .DEPTH       (DEPTH),
      .FLIT_WIDTH  (FLIT_WIDTH),
      .COUNT_WIDTH (CREDIT_COUNT_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_vec[g]),
      .pop_i   (pop_vec[g]),
      .data_i  (in_flit),
      .head_o  (head[g]),
      .count_o (occupancy[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
  end

  always_comb begin
    grant_rr = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_VCS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_VCS;
      if (!found && !empty[idx]) begin
        found    = 1'b1;
        grant_rr = VC_ID_WIDTH'(idx);
      end
    end
  end

  assign grant     = lock_q ? lock_vc_q : grant_rr;
  assign out_valid = ~&empty;
  assign out_vc_id = grant;
  assign out_flit  = head[grant];
  assign pop       = out_valid && out_ready;

  assign return_credit = ret_q;
  assign return_vc_id  = ret_vc_q;
  assign overflow_err  = ovf_q;

  // Full check uses pre-pop counts, so a same-cycle pop never rescues a push.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = out_valid && !out_ready;
    lock_vc_d = grant;
    ret_d     = pop;
    ret_vc_d  = ret_vc_q;
    ovf_d     = ovf_q | (|(push_vec & full));
    if (pop) begin
      rr_ptr_d = (grant == VC_ID_WIDTH'(NUM_VCS - 1)) ? '0 : grant + VC_ID_WIDTH'(1);
      ret_vc_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      ret_q     <= 1'b0;
      ret_vc_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
      ret_q     <= ret_d;
      ret_vc_q  <= ret_vc_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - self-checking bench for vc_input_buffer
module tb_vc_input_buffer;
  import coh_noc_pkg::*;
  localparam int D  = 16;
  localparam int NV = 4;
  localparam int FW = 128;
  localparam int CW = CREDIT_COUNT_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_vc_id = '0;
  logic [FW-1:0] in_flit = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_vc_id;
  logic [FW-1:0] out_flit;
  logic          return_credit;
  logic [1:0]    return_vc_id;
  logic [CW-1:0] occupancy [NV];
  logic          overflow_err;

  int total = 0;
  int bad   = 0;

  bit [FW-1:0] mq [NV][$];
  int m_rr, m_lvc, m_crvc;
  bit m_lock, m_cr, m_ovf;

  always #5 clk = ~clk;

  vc_input_buffer #(.DEPTH(D), .NUM_VCS(NV), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc_id(in_vc_id), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc_id(out_vc_id), .out_flit(out_flit),
    .return_credit(return_credit), .return_vc_id(return_vc_id),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_any();
    for (int i = 0; i < NV; i++) if (mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Offered VC: frozen while stalled, else first non-empty VC at or after the rr pointer.
  function automatic int m_grant();
    if (m_lock) return m_lvc;
    for (int i = 0; i < NV; i++) if (mq[(m_rr + i) % NV].size() != 0) return (m_rr + i) % NV;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) mq[i].delete();
    m_rr = 0; m_lock = 0; m_lvc = 0; m_cr = 0; m_crvc = 0; m_ovf = 0;
  endtask

  task automatic check_all();
    int g;
    bit v;
    g = m_grant();
    v = m_any();
    chk("out_valid", FW'(out_valid), FW'(v));
    if (v) begin
      chk("out_vc_id", FW'(out_vc_id), FW'(g));
      chk("out_flit", out_flit, mq[g][0]);
    end
    chk("return_credit", FW'(return_credit), FW'(m_cr));
    if (m_cr) chk("return_vc_id", FW'(return_vc_id), FW'(m_crvc));
    for (int i = 0; i < NV; i++) chk($sformatf("occupancy[%0d]", i), FW'(occupancy[i]), FW'(mq[i].size()));
    chk("overflow_err", FW'(overflow_err), FW'(m_ovf));
  endtask

  task automatic step(input bit v, input int vc, input bit [FW-1:0] f, input bit r);
    int  g;
    bit  any, pop;
    @(negedge clk);
    check_all();
    in_valid  = v;
    in_vc_id  = vc[1:0];
    in_flit   = f;
    out_ready = r;
    @(posedge clk);
    g   = m_grant();
    any = m_any();
    pop = any && r;
    if (v) begin
      if (mq[vc].size() >= D) m_ovf = 1'b1;
      else mq[vc].push_back(f);
    end
    if (pop) begin
      void'(mq[g].pop_front());
      m_rr = (g + 1) % NV;
    end
    m_lock = any && !r;
    m_lvc  = g;
    m_cr   = pop;
    if (pop) m_crvc = g;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, FW'(out_valid), '0);
    chk({tag, "_out_vc_id"}, FW'(out_vc_id), '0);
    chk({tag, "_return_credit"}, FW'(return_credit), '0);
    chk({tag, "_return_vc_id"}, FW'(return_vc_id), '0);
    chk({tag, "_overflow_err"}, FW'(overflow_err), '0);
    for (int i = 0; i < NV; i++) chk($sformatf("%s_occ%0d", tag, i), FW'(occupancy[i]), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic bit [FW-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    model_reset();
    #1;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // single flit on VC2, credit returned two cycles after the push
    step(1, 2, FW'(8'hA5), 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // fill VC0 then overflow
    do_reset();
    for (int i = 0; i < D; i++) step(1, 0, rnd_flit(), 0);
    step(0, 0, '0, 0);
    step(1, 0, rnd_flit(), 0);
    step(0, 0, '0, 0);
    step(1, 0, rnd_flit(), 1);
    step(0, 0, '0, 1);

    // round robin across all VCs
    do_reset();
    for (int i = 0; i < 8; i++) step(1, i % NV, rnd_flit(), 0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1);

    // grant lock on VC3 while VC0 arrives
    do_reset();
    step(1, 3, rnd_flit(), 0);
    step(1, 0, rnd_flit(), 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // simultaneous push and pop on VC1
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, rnd_flit(), 0);
    step(1, 1, rnd_flit(), 1);
    step(0, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

    // reset with flits buffered and a credit pulse in flight
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, rnd_flit(), 0);
    step(0, 0, '0, 1);
    #1;
    chk("pending_credit", FW'(return_credit), FW'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // random traffic: a filling phase, then a draining phase
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, NV - 1), rnd_flit(), $urandom_range(0, 2) == 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, NV - 1), rnd_flit(), $urandom_range(0, 3) != 0);
    @(negedge clk);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
